// File: rtl/wr_arbiter_pkg.sv
// Purpose: shared worker-result layout and constructor for the WR receive path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package wr_arbiter_pkg;

  localparam int WORKER_RESULT_WIDTH = 67;

  // Field placement inside one worker result, LSB first.
  localparam int DATA_LSB          = 0;
  localparam int DATA_WIDTH        = 32;
  localparam int COLOR_LSB         = 32;
  localparam int COLOR_WIDTH       = 16;
  localparam int DEST_ADDR_LSB     = 48;
  localparam int DEST_ADDR_WIDTH   = 16;
  localparam int DEST_OPTION_LSB   = 64;
  localparam int DEST_OPTION_WIDTH = 3;

  // Packs {dest_option, dest_addr, color, data} into one worker result.
  function automatic logic [WORKER_RESULT_WIDTH-1:0] make_worker_result(
    input logic [DEST_OPTION_WIDTH-1:0] dest_option,
    input logic [DEST_ADDR_WIDTH-1:0]   dest_addr,
    input logic [COLOR_WIDTH-1:0]       color,
    input logic [DATA_WIDTH-1:0]        data
  );
    logic [WORKER_RESULT_WIDTH-1:0] r;
    r = '0;
    r[DATA_LSB        +: DATA_WIDTH]        = data;
    r[COLOR_LSB       +: COLOR_WIDTH]       = color;
    r[DEST_ADDR_LSB   +: DEST_ADDR_WIDTH]   = dest_addr;
    r[DEST_OPTION_LSB +: DEST_OPTION_WIDTH] = dest_option;
    return r;
  endfunction

endpackage

// File: rtl/wr_fifo2.sv
// Purpose: 2-entry in-order FIFO; head is read straight from storage.
// Latency: a push is visible at the head the cycle after it, when the FIFO was empty.
// Backpressure: caller must not push when full nor pop when empty.
// Ports: clk/rst (sync, active-high), push/push_dat, pop, full, empty, head_dat.
module wr_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      // With one entry held, a push lands in the other slot, so the head
      // stays put while the consumer stalls.
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/wr_arbiter.sv
// Purpose: round-robin merge of NUM_WORKERS worker-result streams into one stream.
// Latency: accept at edge N is on SEND_MU_* after edge N (empty FIFO); 1 result/cycle sustained.
// Backpressure: 2-entry FIFO; worker ready uses only registered occupancy, never SEND_MU_READY.
// Ports: CLK, RST (sync, active-high); RECEIVE_WR_VALID/READY/DATA per worker;
//        SEND_MU_VALID/READY/DATA/SRC merged output; RESULT_COUNT accepted-result total.
module wr_arbiter
  import wr_arbiter_pkg::*;
#(
  parameter  int NUM_WORKERS = 4,
  parameter  int CNT_WIDTH   = 32,
  localparam int W           = WORKER_RESULT_WIDTH,
  localparam int SRC_WIDTH   = $clog2(NUM_WORKERS)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_WORKERS-1:0]     RECEIVE_WR_VALID,
  output logic [NUM_WORKERS-1:0]     RECEIVE_WR_READY,
  input  logic [NUM_WORKERS*W-1:0]   RECEIVE_WR_DATA,
  output logic                       SEND_MU_VALID,
  input  logic                       SEND_MU_READY,
  output logic [W-1:0]               SEND_MU_DATA,
  output logic [SRC_WIDTH-1:0]       SEND_MU_SRC,
  output logic [CNT_WIDTH-1:0]       RESULT_COUNT
);

  localparam int CW = SRC_WIDTH + 1;

  logic                   rst_q;       // high during the first cycle after RST falls
  logic [SRC_WIDTH-1:0]   rr;
  logic [CNT_WIDTH-1:0]   result_cnt;
  logic                   grant_vld;
  logic [SRC_WIDTH-1:0]   grant_idx;
  logic [W-1:0]           grant_dat;
  logic                   accept;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [SRC_WIDTH+W-1:0] head;

  // Scan rr, rr+1, ... modulo NUM_WORKERS. Walking the offsets from the far
  // end down lets the nearest valid worker overwrite any later candidate.
  always_comb begin : rr_grant
    logic [CW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_WORKERS - 1; k >= 0; k--) begin
      cand = {1'b0, rr} + CW'(k);
      if (cand >= CW'(NUM_WORKERS)) begin
        cand = cand - CW'(NUM_WORKERS);
      end
      if (RECEIVE_WR_VALID[cand[SRC_WIDTH-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[SRC_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    grant_dat = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      if (grant_idx == SRC_WIDTH'(i)) begin
        grant_dat = RECEIVE_WR_DATA[i*W +: W];
      end
    end
  end

  assign accept = !RST && !rst_q && !fifo_full && grant_vld;

  always_comb begin
    RECEIVE_WR_READY = '0;
    if (accept) begin
      RECEIVE_WR_READY[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rst_q      <= 1'b1;
      rr         <= '0;
      result_cnt <= '0;
    end else begin
      rst_q <= 1'b0;
      if (accept) begin
        rr         <= (grant_idx == SRC_WIDTH'(NUM_WORKERS - 1)) ? '0 : grant_idx + 1'b1;
        result_cnt <= result_cnt + 1'b1;
      end
    end
  end

  wr_fifo2 #(
    .W (SRC_WIDTH + W)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (accept),
    .push_dat ({grant_idx, grant_dat}),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head)
  );

  // Outputs read as idle/zero while RST is held, whatever the stale state is.
  assign SEND_MU_VALID = !RST && !fifo_empty;
  assign fifo_pop      = SEND_MU_VALID && SEND_MU_READY;
  assign SEND_MU_DATA  = RST ? '0 : head[W-1:0];
  assign SEND_MU_SRC   = RST ? '0 : head[W +: SRC_WIDTH];
  assign RESULT_COUNT  = RST ? '0 : result_cnt;

endmodule
